// File: rtl/load_store_unit_if.sv
// Data-memory request/response channel between the LSU and memory.
// The LSU drives requests as master; memory answers as slave.
interface load_store_unit_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one data-memory transaction per load/store, with
// alignment checks, byte lanes, load extension and a request timeout.
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic                      store,
    input  logic [2:0]                funct3,
    input  logic [31:0]               addr,
    input  logic [31:0]               wdata,
    output logic                      stall,
    output logic                      done,
    output logic                      err,
    output logic [31:0]               rdata,
    load_store_unit_if.master         mem
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [CW-1:0] cnt_q;

    logic        start;
    logic        ld_ok;
    logic        st_ok;
    logic        misaligned;
    logic        illegal;
    logic        busy;
    logic        resp_ok;
    logic        tmo;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ext;
    logic [3:0]  mask;
    logic [31:0] lanes;

    assign start = load | store;
    assign ld_ok = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    assign st_ok = funct3 inside {3'b000, 3'b001, 3'b010};
    assign misaligned = (funct3[1:0] == 2'b01 && addr[0])
                      | (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    assign illegal = (load & store) | (load & ~ld_ok)
                   | (store & ~st_ok) | misaligned;

    assign busy    = (state_q == REQ) || (state_q == WAIT);
    assign resp_ok = (state_q == WAIT) && mem.mem_resp_valid;
    // A response arriving on the last allowed cycle still wins.
    assign tmo     = busy && (cnt_q == CW'(TIMEOUT - 1)) && !resp_ok;

    assign lane_b = mem.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign lane_h = mem.mem_rdata[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        ext = mem.mem_rdata;
        case (f3_q)
            3'b000:  ext = {{24{lane_b[7]}}, lane_b};
            3'b001:  ext = {{16{lane_h[15]}}, lane_h};
            3'b100:  ext = {24'd0, lane_b};
            3'b101:  ext = {16'd0, lane_h};
            default: ext = mem.mem_rdata;
        endcase
    end

    always_comb begin
        mask  = 4'b1111;
        lanes = wdata_q;
        case (f3_q[1:0])
            2'b00: begin
                mask  = 4'b0001 << addr_q[1:0];
                lanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                mask  = 4'b0011 << addr_q[1:0];
                lanes = {2{wdata_q[15:0]}};
            end
            default: begin
                mask  = 4'b1111;
                lanes = wdata_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = illegal ? DONE : REQ;
            REQ: begin
                if (tmo)
                    state_d = DONE;
                else if (mem.mem_req_ready)
                    state_d = WAIT;
            end
            WAIT: if (resp_ok || tmo) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        we_q    <= store;
                        f3_q    <= funct3;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        rdata_q <= 32'd0;
                        err_q   <= illegal;
                        cnt_q   <= '0;
                    end
                end
                REQ, WAIT: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (resp_ok)
                        rdata_q <= we_q ? 32'd0 : ext;
                    else if (tmo)
                        err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        stall             = rst_n & (((state_q == IDLE) & start) | busy);
        done              = (state_q == DONE);
        err               = done & err_q;
        rdata             = done ? rdata_q : 32'd0;
        mem.mem_req_valid = (state_q == REQ);
        mem.mem_we        = (state_q == REQ) & we_q;
        mem.mem_addr      = (state_q == REQ) ? {addr_q[31:2], 2'b00} : 32'd0;
        mem.mem_wmask     = mem.mem_we ? mask : 4'd0;
        mem.mem_wdata     = mem.mem_we ? lanes : 32'd0;
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases then random loads/stores
// checked against an arithmetic model of the access rules.
module tb_load_store_unit;
    localparam int TMO = 8;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic        store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic        err;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;

    load_store_unit_if mem ();

    load_store_unit #(.TIMEOUT(TMO)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .store  (store),
        .funct3 (funct3),
        .addr   (addr),
        .wdata  (wdata),
        .stall  (stall),
        .done   (done),
        .err    (err),
        .rdata  (rdata),
        .mem    (mem)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_legal(bit ld, bit st, int f3, int unsigned a);
        int sz = f3 % 4;
        if (ld && st) return 0;
        if (ld && !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5))
            return 0;
        if (st && f3 > 2) return 0;
        if (sz == 1 && a % 2 != 0) return 0;
        if (sz == 2 && a % 4 != 0) return 0;
        return 1;
    endfunction

    function automatic logic [31:0] m_load(int f3, int unsigned a,
                                           logic [31:0] word);
        int unsigned off = a % 4;
        logic [31:0] b = (word >> (8 * off)) & 32'hFF;
        logic [31:0] h = (word >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            0: return (b >= 128) ? b - 32'd256 : b;
            1: return (h >= 32768) ? h - 32'd65536 : h;
            4: return b;
            5: return h;
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] m_mask(int f3, int unsigned a);
        int unsigned off = a % 4;
        case (f3 % 4)
            0: return 32'd1 << off;
            1: return 32'd3 << off;
            default: return 32'd15;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(int f3, logic [31:0] wd);
        case (f3 % 4)
            0: return (wd & 32'hFF) * 32'h01010101;
            1: return (wd & 32'hFFFF) * 32'h00010001;
            default: return wd;
        endcase
    endfunction

    task automatic run_op(input bit ld, input bit st, input int f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int rdy_wait,
                          input int resp_wait, input bit no_resp);
        bit legal = m_legal(ld, st, f3, a);
        bit timeout = legal && no_resp;
        int exp_n;
        int n = 0;
        int k = 0;
        int w = 0;
        bit in_wait = 0;
        logic [31:0] exp_rd;
        exp_n = !legal ? 1 : timeout ? TMO + 1 : rdy_wait + resp_wait + 3;
        exp_rd = (!legal || timeout || st) ? 32'd0 : m_load(f3, a, rd);
        load = ld;
        store = st;
        funct3 = 3'(f3);
        addr = a;
        wdata = wd;
        mem.mem_req_ready = 1'b0;
        mem.mem_resp_valid = 1'b0;
        #1;
        chk("stall_start", stall, 1);
        chk("valid_start", mem.mem_req_valid, 0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (done === 1'b1) break;
            chk("stall_busy", stall, 1);
            if (!in_wait) begin
                chk("req_valid", mem.mem_req_valid, 1);
                chk("req_addr", mem.mem_addr, a - (a % 4));
                chk("req_we", mem.mem_we, st);
                chk("req_wmask", mem.mem_wmask, st ? m_mask(f3, a) : 0);
                if (st) chk("req_wdata", mem.mem_wdata, m_wdata(f3, wd));
                mem.mem_resp_valid = 1'($urandom_range(0, 1));
                mem.mem_rdata = $urandom;
                if (k >= rdy_wait) begin
                    mem.mem_req_ready = 1'b1;
                    in_wait = 1;
                end
                k++;
            end else begin
                mem.mem_req_ready = 1'b0;
                chk("wait_valid", mem.mem_req_valid, 0);
                if (!no_resp && w >= resp_wait) begin
                    mem.mem_resp_valid = 1'b1;
                    mem.mem_rdata = rd;
                end else begin
                    mem.mem_resp_valid = 1'b0;
                    mem.mem_rdata = $urandom;
                end
                w++;
            end
        end
        chk("latency", n, exp_n);
        chk("done", done, 1);
        chk("err", err, !legal || timeout);
        chk("rdata", rdata, exp_rd);
        chk("stall_done", stall, 0);
        chk("valid_done", mem.mem_req_valid, 0);
        load = 1'b0;
        store = 1'b0;
        mem.mem_req_ready = 1'b0;
        mem.mem_resp_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("done_pulse", done, 0);
        chk("stall_idle", stall, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        load = 1'b0;
        store = 1'b0;
        funct3 = 3'd0;
        addr = 32'd0;
        wdata = 32'd0;
        mem.mem_req_ready = 1'b0;
        mem.mem_resp_valid = 1'b0;
        mem.mem_rdata = 32'd0;
        #12;
        chk("rst_stall", stall, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_valid", mem.mem_req_valid, 0);
        chk("rst_wmask", mem.mem_wmask, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_op(1, 0, 2, 32'h80000004, 32'h0, 32'hDEADBEEF, 0, 0, 0);
        run_op(1, 0, 0, 32'h80000003, 32'h0, 32'h80FF1234, 0, 0, 0);
        run_op(1, 0, 4, 32'h80000003, 32'h0, 32'h80FF1234, 0, 0, 0);
        run_op(0, 1, 1, 32'h80000002, 32'h0000ABCD, 32'h0, 0, 0, 0);
        run_op(0, 1, 2, 32'h80000010, 32'h12345678, 32'h0, 5, 1, 0);
        run_op(1, 0, 2, 32'h80000002, 32'h0, 32'h0, 0, 0, 0);
        run_op(1, 0, 2, 32'h80000008, 32'h0, 32'h0, 2, 0, 1);
        run_op(1, 1, 2, 32'h80000008, 32'h0, 32'h0, 0, 0, 0);
        run_op(0, 1, 4, 32'h80000008, 32'h0, 32'h0, 0, 0, 0);

        // abort in WAIT: outputs must drop without a clock edge
        load = 1'b1;
        funct3 = 3'd2;
        addr = 32'h80000020;
        mem.mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        mem.mem_req_ready = 1'b0;
        chk("wait_stall", stall, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_stall", stall, 0);
        chk("arst_done", done, 0);
        chk("arst_err", err, 0);
        chk("arst_rdata", rdata, 0);
        chk("arst_valid", mem.mem_req_valid, 0);
        chk("arst_we", mem.mem_we, 0);
        chk("arst_addr", mem.mem_addr, 0);
        chk("arst_wmask", mem.mem_wmask, 0);
        chk("arst_wdata", mem.mem_wdata, 0);
        load = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_stall", stall, 0);
        chk("post_rst_valid", mem.mem_req_valid, 0);
        mem.mem_resp_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("stray_resp_done", done, 0);
        mem.mem_resp_valid = 1'b0;

        for (int i = 0; i < 30; i++) begin
            int kind = $urandom_range(0, 9);
            bit ld = (kind <= 5);
            bit st = (kind == 0) || (kind >= 6);
            int f3 = $urandom_range(0, 7);
            if ($urandom_range(0, 3) != 0)
                f3 = st && !ld ? $urandom_range(0, 2)
                               : (($urandom_range(0, 1) != 0) ? 4 : 0)
                                 + $urandom_range(0, 1) + 0;
            run_op(ld, st, f3, $urandom, $urandom, $urandom,
                   $urandom_range(0, 2), $urandom_range(0, 2), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
